// File: rtl/cf_fft_1024_8_phase_seq.sv
// cf_fft_1024_8_phase_seq: frame/phase sequencer and per-phase lane capture for the bit-serial FFT
module cf_fft_1024_8_phase_seq #(
  parameter int COUNT_W = 10,
  parameter int PHASE_W = 3
) (
  input  logic               clock_c,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               sync_i,
  input  logic               data_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               valid_o,
  output logic               sync_o,
  output logic               lane_def_o,
  output logic               lane_p2_o,
  output logic               lane_p4_o,
  output logic               lane_p6_o,
  output logic               resync_err_o
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [COUNT_W-1:0] count_n;
  logic [PHASE_W-1:0] ph_n;
  logic sync_n, err_n, acc, at_end, is_p2, is_p4, is_p6;
  assign at_end = &count_o;
  assign acc = enable_i & ((state == RUN) | sync_i);
  assign valid_o = (state == RUN);
  assign phase_o = count_o[PHASE_W-1:0];
  always_comb begin
    state_n = state;
    count_n = count_o;
    sync_n = 1'b0;
    err_n = resync_err_o;
    if (enable_i && state == IDLE && sync_i) begin
      state_n = RUN;
      count_n = '0;
      sync_n = 1'b1;
    end else if (enable_i && state == RUN) begin
      count_n = sync_i ? '0 : count_o + 1'b1;
      sync_n = sync_i | at_end;
      err_n = resync_err_o | (sync_i & ~at_end);
    end
  end
  // lanes are keyed on the phase the incoming sample is about to take
  assign ph_n = count_n[PHASE_W-1:0];
  assign is_p2 = (ph_n == PHASE_W'(2));
  assign is_p4 = (ph_n == PHASE_W'(4));
  assign is_p6 = (ph_n == PHASE_W'(6));
  always_ff @(posedge clock_c) begin
    if (reset_i) begin
      state <= IDLE;
      count_o <= '0;
      sync_o <= 1'b0;
      resync_err_o <= 1'b0;
      lane_def_o <= 1'b0;
      lane_p2_o <= 1'b0;
      lane_p4_o <= 1'b0;
      lane_p6_o <= 1'b0;
    end else begin
      state <= state_n;
      count_o <= count_n;
      sync_o <= sync_n;
      resync_err_o <= err_n;
      lane_p2_o <= (acc && is_p2) ? data_i : lane_p2_o;
      lane_p4_o <= (acc && is_p4) ? data_i : lane_p4_o;
      lane_p6_o <= (acc && is_p6) ? data_i : lane_p6_o;
      lane_def_o <= (acc && !(is_p2 || is_p4 || is_p6)) ? data_i : lane_def_o;
    end
  end
endmodule

// File: tb/tb_cf_fft_1024_8_phase_seq.sv
// tb_cf_fft_1024_8_phase_seq: scoreboard bench with a frame-level reference model
module tb_cf_fft_1024_8_phase_seq;
  logic clock_c = 1'b0, reset_i = 1'b1, enable_i = 1'b0, sync_i = 1'b0, data_i = 1'b0;
  logic [2:0] phase_o;
  logic [9:0] count_o;
  logic valid_o, sync_o, lane_def_o, lane_p2_o, lane_p4_o, lane_p6_o, resync_err_o;
  cf_fft_1024_8_phase_seq dut (
    .clock_c(clock_c), .reset_i(reset_i), .enable_i(enable_i), .sync_i(sync_i), .data_i(data_i),
    .phase_o(phase_o), .count_o(count_o), .valid_o(valid_o), .sync_o(sync_o),
    .lane_def_o(lane_def_o), .lane_p2_o(lane_p2_o), .lane_p4_o(lane_p4_o), .lane_p6_o(lane_p6_o),
    .resync_err_o(resync_err_o)
  );
  always #5 clock_c = ~clock_c;
  typedef struct packed {
    logic [2:0] ph;
    logic [9:0] cnt;
    logic v, s, ld, l2, l4, l6, e;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int m_cnt = 0;
  bit m_run = 0, m_err = 0, m_sync = 0;
  bit m_lane[4] = '{0, 0, 0, 0};
  task automatic chk(string n, logic [31:0] a, logic [31:0] ex);
    checks++;
    if (a !== ex) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, ex);
    end
  endtask
  // model: frame position as an integer, lanes indexed by destination
  task automatic step(bit r, bit e, bit s, bit d);
    exp_t x;
    int ph;
    if (r) begin
      m_run = 0; m_cnt = 0; m_err = 0; m_sync = 0;
      m_lane = '{0, 0, 0, 0};
    end else if (e && (m_run || s)) begin
      if (m_run && s && m_cnt != 1023) m_err = 1;
      m_cnt = s ? 0 : (m_cnt + 1) % 1024;
      m_run = 1;
      m_sync = (m_cnt == 0);
      ph = m_cnt % 8;
      m_lane[ph == 2 ? 1 : ph == 4 ? 2 : ph == 6 ? 3 : 0] = d;
    end else m_sync = 0;
    x.ph = 3'(m_cnt % 8); x.cnt = 10'(m_cnt); x.v = m_run; x.s = m_sync;
    x.ld = m_lane[0]; x.l2 = m_lane[1]; x.l4 = m_lane[2]; x.l6 = m_lane[3]; x.e = m_err;
    q.push_back(x);
  endtask
  task automatic cyc(bit r, bit e, bit s, bit d);
    @(negedge clock_c);
    reset_i = r; enable_i = e; sync_i = s; data_i = d;
    step(r, e, s, d);
  endtask
  task automatic advance_to(int n);
    while (m_cnt != n) cyc(0, $urandom_range(0, 3) != 0, 0, 1'($urandom_range(0, 1)));
  endtask
  initial forever begin
    exp_t x;
    @(posedge clock_c);
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("phase", phase_o, x.ph);
      chk("count", count_o, x.cnt);
      chk("valid", valid_o, x.v);
      chk("sync", sync_o, x.s);
      chk("lane_def", lane_def_o, x.ld);
      chk("lane_p2", lane_p2_o, x.l2);
      chk("lane_p4", lane_p4_o, x.l4);
      chk("lane_p6", lane_p6_o, x.l6);
      chk("resync_err", resync_err_o, x.e);
    end
  end
  bit pat[8] = '{0, 1, 1, 0, 1, 0, 0, 1};
  initial begin
    repeat (2) cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (10) cyc(0, 1, 0, 1'($urandom_range(0, 1)));
    cyc(0, 1, 1, 1);
    for (int i = 1; i < 8; i++) begin
      if (i == 6) repeat (3) cyc(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc(0, 1, 0, pat[i]);
    end
    advance_to(1023);
    cyc(0, 1, 0, 1'($urandom_range(0, 1)));
    advance_to(300);
    cyc(0, 1, 1, 1'($urandom_range(0, 1)));
    advance_to(1023);
    cyc(0, 1, 1, 1'($urandom_range(0, 1)));
    advance_to(700);
    cyc(1, 1, 1, 1);
    repeat (3) cyc(0, 1, 0, 1'($urandom_range(0, 1)));
    cyc(0, 1, 1, 1'($urandom_range(0, 1)));
    repeat (80) cyc(0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)));
    @(negedge clock_c);
    enable_i = 0; sync_i = 0;
    @(posedge clock_c);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cf_fft_1024_8_phase_seq.md
Name: cf_fft_1024_8_phase_seq

Overview:
- Upstream sequencer for the 1024-point, 8-phase bit-serial FFT datapath.
- Tracks sample position within the frame from the frame sync. Produces the 3-bit phase that drives the downstream per-phase bit selectors.
- Registers the incoming serial data bit into the lane each selector consumes: phase-2, phase-4, phase-6, or default.
- Flags frame-sync misalignment.

Parameters:
- COUNT_W, 10, sample counter width; frame length is 2**COUNT_W samples.
- PHASE_W, 3, phase width; phase is count[PHASE_W-1:0]. Fixed at 3 for this datapath.

Ports:
- clock_c  input  1  clock; all logic rising-edge.
- reset_i  input  1  synchronous, active-high reset.
- enable_i  input  1  sample strobe; when low, all state holds.
- sync_i  input  1  marks the current enabled sample as sample 0 of a frame.
- data_i  input  1  serial data bit of the current sample.
- phase_o  output  3  phase of the last accepted sample.
- count_o  output  COUNT_W  index of the last accepted sample.
- valid_o  output  1  high while in RUN (outputs meaningful).
- sync_o  output  1  one-cycle pulse when count_o becomes 0.
- lane_def_o  output  1  last bit accepted at phase 0, 1, 3, 5 or 7.
- lane_p2_o  output  1  last bit accepted at phase 2.
- lane_p4_o  output  1  last bit accepted at phase 4.
- lane_p6_o  output  1  last bit accepted at phase 6.
- resync_err_o  output  1  sticky misaligned-sync flag.

Behaviour:
- Reset (reset_i=1 at an edge): state=IDLE; every output is 0 on the next cycle. Reset overrides all other inputs, including mid-frame.
- Accepted sample: any cycle with enable_i=1. Outputs are registered and describe the sample accepted in the most recent accepted cycle (latency 1 from acceptance).
- enable_i=0: state, count, lanes and flags hold. sync_o is forced to 0.
- IDLE:
  - Ignores data_i.
  - enable_i&sync_i: next cycle state=RUN, count_o=0, phase_o=0, sync_o=1, valid_o=1, lane_def_o=data_i.
  - enable_i without sync_i: stay in IDLE, no output change.
- RUN, accepted sample without sync_i:
  - count_o <= count_o+1, modulo 2**COUNT_W. 1023 wraps to 0 and RUN continues (free-running frames).
  - sync_o=1 only on the wrap cycle.
- RUN, accepted sample with sync_i:
  - count_o <= 0 and sync_o=1.
  - If the previous count_o != 2**COUNT_W-1 (sync not at a frame boundary): resync_err_o <= 1, sticky until reset.
  - A sync exactly at the wrap point is legal and sets no error.
- Phase and lane capture:
  - phase_o always equals count_o[2:0].
  - Lane capture uses the phase the sample takes, i.e. the next count_o[2:0]:
    - phase 2 -> lane_p2_o
    - phase 4 -> lane_p4_o
    - phase 6 -> lane_p6_o
    - otherwise -> lane_def_o
  - Exactly one lane updates per accepted sample; the others hold.
- Simultaneous reset_i and sync_i: reset wins, state=IDLE.
- There is no way back to IDLE except reset.

Test Plan:
- Reset then idle: reset_i=1 for 2 cycles, then enable_i=1, sync_i=0 for 10 cycles -> all outputs 0 throughout, valid_o=0.
- Frame start: enable_i=1, sync_i pulse with data_i=1 -> next cycle count_o=0, phase_o=0, sync_o=1, valid_o=1, lane_def_o=1. The following cycle sync_o=0, count_o=1.
- Lane routing: after sync, feed data_i pattern 0,1,1,0,1,0,0,1 for phases 0..7 -> after phase 2 lane_p2_o=1; after phase 4 lane_p4_o=1; after phase 6 lane_p6_o=0; after phase 7 lane_def_o=1.
- Stall and wrap:
  - Insert enable_i=0 gaps at count 5 (3 cycles) -> count_o, phase_o and lanes frozen at 5; sync_o=0.
  - Continue to count 1023, then one more accepted sample -> count_o=0, sync_o=1, resync_err_o=0.
- Resync:
  - sync_i at count_o=300 -> next count_o=0, sync_o=1, resync_err_o=1 and stays 1.
  - Later sync_i exactly at count 1023 -> resync_err_o remains 1.
- Reset mid-frame: reset_i at count_o=700 together with sync_i=1 -> next cycle all outputs 0, state IDLE. A fresh sync restarts at count 0 with resync_err_o=0.
